// File: rtl/rock_ctrl_pkg.sv
// rock_ctrl_pkg: shared definitions for the rocking-actuator control blocks.
//   LVL_W          width of an amplitude/frequency level
//   MAX_LEVEL_DEF  default highest legal level
//   state_t        sequencer states IDLE / RAMP / DONE
//   step_toward()  move a level one step toward a target, or hold when equal
package rock_ctrl_pkg;

    localparam int LVL_W         = 3;
    localparam int MAX_LEVEL_DEF = 5;

    typedef logic [LVL_W-1:0] lvl_t;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        DONE
    } state_t;

    // Moves by at most one level. The target is always within 0..MAX_LEVEL,
    // so the result can never wrap.
    function automatic lvl_t step_toward(input lvl_t cur, input lvl_t tgt);
        if (cur < tgt)
            return cur + lvl_t'(1);
        else if (cur > tgt)
            return cur - lvl_t'(1);
        return cur;
    endfunction

endpackage

// File: rtl/rock_step_timer.sv
// rock_step_timer: free-running dwell counter with terminal-count pulse.
//   clk, reset  clock and asynchronous active-high reset
//   en          count enable
//   clr         synchronous clear to 0 (takes priority over en)
//   tc          high in the cycle whose rising edge completes STEP_CYCLES
//               counts; the counter reloads 0 on that edge
module rock_step_timer #(
    parameter int unsigned STEP_CYCLES = 50_000_000,
    parameter int          CNT_W       = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/rock_ramp_sequencer.sv
// rock_ramp_sequencer: walks the amplitude (A) and frequency (F) setpoints
// toward a requested target one level per dwell period, with emergency
// ramp-down (halt) and range checking of requests.
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready target handshake (ready only in IDLE with halt low)
//   tgt_a, tgt_f        requested levels
//   halt                level-sensitive stop: ramp both setpoints to 0
//   A, F                current setpoints to the generator
//   busy                ramp in progress
//   done                one-cycle pulse when a ramp reaches its target
//   err                 one-cycle pulse after an out-of-range request
// Optional: define ROCK_WATCHDOG_EN to add an idle-with-motion watchdog that
// ramps to 0 after WDOG_CYCLES idle cycles and latches err until reset.
module rock_ramp_sequencer
    import rock_ctrl_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 50_000_000,
    parameter int          CNT_W       = 26,
    parameter int unsigned MAX_LEVEL   = MAX_LEVEL_DEF,
    parameter int unsigned WDOG_CYCLES = 32'd3_000_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LVL_W-1:0] tgt_a,
    input  logic [LVL_W-1:0] tgt_f,
    input  logic             halt,
    output logic [LVL_W-1:0] A,
    output logic [LVL_W-1:0] F,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam lvl_t MAX_L = lvl_t'(MAX_LEVEL);

    state_t state, state_n;
    lvl_t   tgt_a_r, tgt_f_r;
    lvl_t   a_n, f_n, ta_n, tf_n, eff_a, eff_f;
    logic   err_p, err_p_n;
    logic   accept, motion, range_bad, step_tc, wd_fire;

    assign req_ready = (state == IDLE) && !halt;
    assign accept    = req_valid && req_ready;
    assign motion    = (A != '0) || (F != '0);
    assign range_bad = (tgt_a > MAX_L) || (tgt_f > MAX_L);
    assign busy      = (state == RAMP);
    assign done      = (state == DONE);

    // The dwell counter sits at 0 outside RAMP, so every ramp (including one
    // started by halt) begins a fresh dwell, while halt raised mid-ramp does
    // not restart it.
    rock_step_timer #(
        .STEP_CYCLES(STEP_CYCLES),
        .CNT_W      (CNT_W)
    ) u_step (
        .clk  (clk),
        .reset(reset),
        .en   (state == RAMP),
        .clr  (state != RAMP),
        .tc   (step_tc)
    );

`ifdef ROCK_WATCHDOG_EN
    logic wd_err;

    rock_step_timer #(
        .STEP_CYCLES(WDOG_CYCLES),
        .CNT_W      (32)
    ) u_wdog (
        .clk  (clk),
        .reset(reset),
        .en   ((state == IDLE) && motion),
        .clr  (!((state == IDLE) && motion) || accept),
        .tc   (wd_fire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd_err <= 1'b0;
        else if (wd_fire)
            wd_err <= 1'b1;
    end

    assign err = err_p | wd_err;
`else
    assign wd_fire = 1'b0;
    assign err     = err_p;

    if (WDOG_CYCLES == 0) begin : g_no_wdog
    end
`endif

    always_comb begin
        state_n = state;
        a_n     = A;
        f_n     = F;
        ta_n    = tgt_a_r;
        tf_n    = tgt_f_r;
        err_p_n = 1'b0;
        // halt overrides the stored targets immediately, even mid-dwell
        eff_a   = halt ? '0 : tgt_a_r;
        eff_f   = halt ? '0 : tgt_f_r;

        if (halt) begin
            ta_n = '0;
            tf_n = '0;
        end

        case (state)
            IDLE: begin
                if (halt) begin
                    if (motion)
                        state_n = RAMP;
                end else if (wd_fire) begin
                    ta_n    = '0;
                    tf_n    = '0;
                    state_n = RAMP;
                end else if (accept) begin
                    if (range_bad) begin
                        err_p_n = 1'b1;
                    end else begin
                        ta_n    = tgt_a;
                        tf_n    = tgt_f;
                        state_n = (tgt_a == A && tgt_f == F) ? DONE : RAMP;
                    end
                end
            end
            RAMP: begin
                if (step_tc) begin
                    a_n = step_toward(A, eff_a);
                    f_n = step_toward(F, eff_f);
                    if (a_n == eff_a && f_n == eff_f)
                        state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            A       <= '0;
            F       <= '0;
            tgt_a_r <= '0;
            tgt_f_r <= '0;
            err_p   <= 1'b0;
        end else begin
            state   <= state_n;
            A       <= a_n;
            F       <= f_n;
            tgt_a_r <= ta_n;
            tgt_f_r <= tf_n;
            err_p   <= err_p_n;
        end
    end

endmodule

// File: tb/tb_rock_ramp_sequencer.sv
module tb_rock_ramp_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       halt;
    logic [2:0] tgt_a, tgt_f;
    logic       req_ready, busy, done, err;
    logic [2:0] A, F;

    int nvec  = 0;
    int nfail = 0;
    int cur_a = 0;
    int cur_f = 0;

    always #5 clk = ~clk;

    rock_ramp_sequencer #(
        .STEP_CYCLES(4),
        .CNT_W      (4),
        .MAX_LEVEL  (5),
        .WDOG_CYCLES(20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .tgt_a    (tgt_a),
        .tgt_f    (tgt_f),
        .halt     (halt),
        .A        (A),
        .F        (F),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        int ta;
        int tf;
        int ea;
        int ef;
        int eerr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Level after k dwell steps from a0 toward t: plain saturating distance.
    function automatic int toward(input int a0, input int t, input int k);
        if (t > a0)
            return (a0 + k < t) ? a0 + k : t;
        return (a0 - k > t) ? a0 - k : t;
    endfunction

    // Issue one request from IDLE and follow the whole transaction.
    task automatic do_req(input int ta, input int tf, output int err_seen);
        int da, df, s;
        req_valid = 1'b1;
        tgt_a     = 3'(ta);
        tgt_f     = 3'(tf);
        #1;
        chk("ready_before_req", req_ready, 1);
        tick;
        req_valid = 1'b0;
        err_seen  = int'(err);
        if (ta > 5 || tf > 5) begin
            chk("err_pulse", err, 1);
            chk("a_hold_on_err", A, cur_a);
            chk("f_hold_on_err", F, cur_f);
            chk("busy_on_err", busy, 0);
            tick;
            chk("err_one_cycle", err, 0);
            chk("ready_after_err", req_ready, 1);
        end else begin
            da = (ta > cur_a) ? ta - cur_a : cur_a - ta;
            df = (tf > cur_f) ? tf - cur_f : cur_f - tf;
            s  = (da > df) ? da : df;
            for (int n = 0; n <= 4 * s + 1; n++) begin
                if (n > 0) tick;
                chk("ramp_a", A, toward(cur_a, ta, n / 4));
                chk("ramp_f", F, toward(cur_f, tf, n / 4));
                chk("busy", busy, (n < 4 * s) ? 1 : 0);
                chk("done", done, (n == 4 * s) ? 1 : 0);
                chk("ready", req_ready, (n == 4 * s + 1) ? 1 : 0);
            end
            cur_a = ta;
            cur_f = tf;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, gap, waited;

        tbl[0] = '{3, 2, 3, 2, 0};
        tbl[1] = '{1, 4, 1, 4, 0};
        tbl[2] = '{6, 1, 1, 4, 1};
        tbl[3] = '{1, 4, 1, 4, 0};
        tbl[4] = '{2, 7, 1, 4, 1};
        tbl[5] = '{5, 0, 5, 0, 0};
        tbl[6] = '{0, 1, 0, 1, 0};

        reset     = 1'b1;
        req_valid = 1'b0;
        halt      = 1'b0;
        tgt_a     = '0;
        tgt_f     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick;
        chk("rst_a", A, 0);
        chk("rst_f", F, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", req_ready, 1);

        // Table-driven transactions
        for (int i = 0; i < 7; i++) begin
            do_req(tbl[i].ta, tbl[i].tf, e);
            chk("tbl_err", e, tbl[i].eerr);
            chk("tbl_final_a", A, tbl[i].ea);
            chk("tbl_final_f", F, tbl[i].ef);
        end

        // Halt mid-ramp together with a request, starting from A=0,F=1
        req_valid = 1'b1;
        tgt_a     = 3'd5;
        tgt_f     = 3'd5;
        tick;
        req_valid = 1'b0;
        repeat (8) tick;
        chk("pre_halt_a", A, 2);
        chk("pre_halt_f", F, 3);
        halt      = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("halt_ready", req_ready, 0);
        for (int m = 1; m <= 16; m++) begin
            tick;
            chk("halt_a", A, toward(2, 0, m / 4));
            chk("halt_f", F, toward(3, 0, m / 4));
            chk("halt_done", done, (m == 12) ? 1 : 0);
            chk("halt_busy", busy, (m < 12) ? 1 : 0);
            chk("halt_ready_low", req_ready, 0);
        end
        halt      = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("ready_after_halt", req_ready, 1);
        cur_a = 0;
        cur_f = 0;

        // Halt raised while idle with motion starts a ramp to 0
        do_req(1, 0, e);
        halt = 1'b1;
        tick;
        chk("idle_halt_busy", busy, 1);
        for (int m = 1; m <= 5; m++) begin
            tick;
            chk("idle_halt_a", A, toward(1, 0, m / 4));
            chk("idle_halt_done", done, (m == 4) ? 1 : 0);
        end
        halt = 1'b0;
        cur_a = 0;
        cur_f = 0;

        // Asynchronous reset between clock edges mid-ramp
        req_valid = 1'b1;
        tgt_a     = 3'd3;
        tgt_f     = 3'd3;
        tick;
        req_valid = 1'b0;
        repeat (6) tick;
        chk("pre_reset_a", A, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_a", A, 0);
        chk("async_rst_f", F, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        tick;
        cur_a = 0;
        cur_f = 0;

        // Randomized transactions against the closed-form model
        for (int r = 0; r < 30; r++) begin
            do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), e);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick;
                chk("idle_a", A, cur_a);
                chk("idle_f", F, cur_f);
                chk("idle_busy", busy, 0);
            end
        end

        // Idle with motion at A=2,F=2
        do_req(2, 2, e);
`ifdef ROCK_WATCHDOG_EN
        waited = 0;
        while (!busy && waited < 40) begin
            tick;
            waited++;
        end
        chk("wd_fire_time", (waited >= 18 && waited <= 22) ? 1 : 0, 1);
        for (int m = 1; m <= 10; m++) begin
            tick;
            chk("wd_a", A, toward(2, 0, m / 4));
            chk("wd_f", F, toward(2, 0, m / 4));
            chk("wd_done", done, (m == 8) ? 1 : 0);
            chk("wd_err_sticky", err, 1);
        end
        repeat (5) tick;
        chk("wd_err_held", err, 1);
        reset = 1'b1;
        #1;
        chk("wd_err_reset", err, 0);
        @(negedge clk);
        reset = 1'b0;
`else
        waited = 0;
        for (int m = 0; m < 30; m++) begin
            tick;
            waited++;
            chk("nowd_a", A, 2);
            chk("nowd_f", F, 2);
            chk("nowd_err", err, 0);
            chk("nowd_busy", busy, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
